// File: rtl/colored_return_buffer.sv
// Colored return buffer: per-color FIFO regions in one shared RAM, 1-cycle registered read with pop to the credit tracker.
// Optional total-occupancy output "level" when COLORED_RETURN_BUFFER_LEVEL_EN is defined.
module colored_return_buffer #(
  parameter int unsigned COLORS = 4,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned WIDTH  = 64
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                wr_valid,
  input  logic [$clog2(COLORS)-1:0]           wr_tag,
  input  logic [WIDTH-1:0]                    wr_data,
  input  logic                                rd_req,
  input  logic [$clog2(COLORS)-1:0]           rd_tag,
  output logic                                rd_valid,
  output logic [WIDTH-1:0]                    rd_data,
  output logic                                rd_miss,
  output logic [COLORS-1:0]                   nonempty,
  output logic                                pop,
  output logic [$clog2(COLORS)-1:0]           pop_tag,
  output logic                                overflow
`ifdef COLORED_RETURN_BUFFER_LEVEL_EN
  ,
  output logic [$clog2(COLORS*DEPTH):0]       level
`endif
);

  localparam int unsigned TAG_W  = $clog2(COLORS);
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned ADDR_W = TAG_W + PTR_W;
  localparam int unsigned ENTRIES = COLORS * DEPTH;

  logic [WIDTH-1:0] mem [ENTRIES];
  logic [PTR_W-1:0] wptr    [COLORS];
  logic [PTR_W-1:0] rptr    [COLORS];
  logic [CNT_W-1:0] cnt     [COLORS];
  logic [CNT_W-1:0] cnt_nxt [COLORS];

  logic              wr_ok;
  logic              rd_ok;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;

  // Full/empty decisions both use the pre-cycle count of the addressed color.
  always_comb begin
    wr_ok   = wr_valid && (cnt[wr_tag] != CNT_W'(DEPTH));
    rd_ok   = rd_req && (cnt[rd_tag] != '0);
    wr_addr = {wr_tag, wptr[wr_tag]};
    rd_addr = {rd_tag, rptr[rd_tag]};
  end

  always_comb begin
    for (int c = 0; c < COLORS; c++) begin
      cnt_nxt[c] = cnt[c];
      if (wr_ok && (wr_tag == TAG_W'(c))) begin
        cnt_nxt[c] = cnt_nxt[c] + CNT_W'(1);
      end
      if (rd_ok && (rd_tag == TAG_W'(c))) begin
        cnt_nxt[c] = cnt_nxt[c] - CNT_W'(1);
      end
    end
  end

  // Storage is not reset; stale entries are unreachable once the counters clear.
  always_ff @(posedge clk) begin
    if (!rst && wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < COLORS; c++) begin
        wptr[c] <= '0;
        rptr[c] <= '0;
        cnt[c]  <= '0;
      end
    end else begin
      if (wr_ok) begin
        wptr[wr_tag] <= wptr[wr_tag] + PTR_W'(1);
      end
      if (rd_ok) begin
        rptr[rd_tag] <= rptr[rd_tag] + PTR_W'(1);
      end
      for (int c = 0; c < COLORS; c++) begin
        cnt[c] <= cnt_nxt[c];
      end
    end
  end

  // Read response and tracker pop, one cycle after the request.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_miss  <= 1'b0;
      pop      <= 1'b0;
      pop_tag  <= '0;
      overflow <= 1'b0;
      nonempty <= '0;
    end else begin
      rd_valid <= rd_ok;
      pop      <= rd_ok;
      rd_miss  <= rd_req && !rd_ok;
      if (rd_ok) begin
        rd_data <= mem[rd_addr];
        pop_tag <= rd_tag;
      end
      if (wr_valid && !wr_ok) begin
        overflow <= 1'b1;
      end
      for (int c = 0; c < COLORS; c++) begin
        nonempty[c] <= (cnt_nxt[c] != '0);
      end
    end
  end

`ifdef COLORED_RETURN_BUFFER_LEVEL_EN
  localparam int unsigned LVL_W = $clog2(ENTRIES) + 1;

  always_ff @(posedge clk) begin
    if (rst) begin
      level <= '0;
    end else begin
      level <= level + LVL_W'(wr_ok) - LVL_W'(rd_ok);
    end
  end
`endif

endmodule

// File: tb/tb_colored_return_buffer.sv
// Self-checking bench for colored_return_buffer: directed table, corner sequences and random traffic vs a queue model.
module tb_colored_return_buffer;

  localparam int unsigned COLORS = 4;
  localparam int unsigned DEPTH  = 32;
  localparam int unsigned WIDTH  = 64;
  localparam int unsigned TAG_W  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_valid;
  logic [TAG_W-1:0]  wr_tag;
  logic [WIDTH-1:0]  wr_data;
  logic              rd_req;
  logic [TAG_W-1:0]  rd_tag;
  logic              rd_valid;
  logic [WIDTH-1:0]  rd_data;
  logic              rd_miss;
  logic [COLORS-1:0] nonempty;
  logic              pop;
  logic [TAG_W-1:0]  pop_tag;
  logic              overflow;
`ifdef COLORED_RETURN_BUFFER_LEVEL_EN
  logic [$clog2(COLORS*DEPTH):0] level;
`endif

  colored_return_buffer #(.COLORS(COLORS), .DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_tag(wr_tag), .wr_data(wr_data),
    .rd_req(rd_req), .rd_tag(rd_tag),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_miss(rd_miss),
    .nonempty(nonempty), .pop(pop), .pop_tag(pop_tag), .overflow(overflow)
`ifdef COLORED_RETURN_BUFFER_LEVEL_EN
    , .level(level)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: one queue per color plus sticky overflow.
  logic [WIDTH-1:0] mq [COLORS][$];
  bit m_ovf;
  int m_pops [COLORS];
  int d_pops [COLORS];

  typedef struct {
    bit              wv;
    int              wt;
    logic [63:0]     wd;
    bit              rr;
    int              rt;
    bit              ev;
    bit              em;
    logic [63:0]     ed;
    logic [3:0]      ene;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [COLORS-1:0] exp_ne();
    logic [COLORS-1:0] r;
    for (int c = 0; c < COLORS; c++) r[c] = (mq[c].size() != 0);
    return r;
  endfunction

  function automatic int total();
    int t = 0;
    for (int c = 0; c < COLORS; c++) t += mq[c].size();
    return t;
  endfunction

  // One clock of traffic: model update, drive, advance, compare everything.
  task automatic step(input bit wv, input int wt, input logic [63:0] wd,
                      input bit rr, input int rt,
                      output bit acc, output logic [63:0] adata);
    bit wok;
    wok   = wv && (mq[wt].size() != DEPTH);
    acc   = rr && (mq[rt].size() != 0);
    adata = '0;
    if (acc) begin
      adata = mq[rt].pop_front();
      m_pops[rt]++;
    end
    if (wv && !wok) m_ovf = 1'b1;
    if (wok) mq[wt].push_back(wd);
    wr_valid = wv;
    wr_tag   = TAG_W'(wt);
    wr_data  = wd;
    rd_req   = rr;
    rd_tag   = TAG_W'(rt);
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
    rd_req   = 1'b0;
    chk("rd_valid", 64'(rd_valid), 64'(acc));
    chk("pop", 64'(pop), 64'(acc));
    chk("rd_miss", 64'(rd_miss), 64'(rr && !acc));
    if (acc) begin
      chk("rd_data", rd_data, adata);
      chk("pop_tag", 64'(pop_tag), 64'(rt));
    end
    if (pop) d_pops[pop_tag]++;
    chk("nonempty", 64'(nonempty), 64'(exp_ne()));
    chk("overflow", 64'(overflow), 64'(m_ovf));
`ifdef COLORED_RETURN_BUFFER_LEVEL_EN
    chk("level", 64'(level), 64'(total()));
`endif
  endtask

  // Two reset cycles with live traffic on the inputs; everything must read back zero.
  task automatic do_reset();
    rst      = 1'b1;
    wr_valid = 1'b1;
    wr_tag   = 2'd1;
    wr_data  = 64'h5555;
    rd_req   = 1'b1;
    rd_tag   = 2'd1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rd_valid", 64'(rd_valid), 64'd0);
    chk("rst_rd_miss", 64'(rd_miss), 64'd0);
    chk("rst_pop", 64'(pop), 64'd0);
    chk("rst_pop_tag", 64'(pop_tag), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_nonempty", 64'(nonempty), 64'd0);
    chk("rst_rd_data", rd_data, 64'd0);
`ifdef COLORED_RETURN_BUFFER_LEVEL_EN
    chk("rst_level", 64'(level), 64'd0);
`endif
    for (int c = 0; c < COLORS; c++) mq[c].delete();
    m_ovf    = 1'b0;
    rst      = 1'b0;
    wr_valid = 1'b0;
    rd_req   = 1'b0;
  endtask

  initial begin
    bit          acc;
    logic [63:0] ad;
    int          t3w;

    for (int c = 0; c < COLORS; c++) begin
      m_pops[c] = 0;
      d_pops[c] = 0;
    end
    wr_data = '0;
    wr_tag  = '0;
    rd_tag  = '0;
    do_reset();

    // Directed FIFO order and same-cycle write+read on an empty color.
    tbl[0] = '{1, 1, 64'hA, 0, 0, 0, 0, 64'h0, 4'b0010};
    tbl[1] = '{1, 1, 64'hB, 0, 0, 0, 0, 64'h0, 4'b0010};
    tbl[2] = '{1, 1, 64'hC, 0, 0, 0, 0, 64'h0, 4'b0010};
    tbl[3] = '{0, 0, 64'h0, 1, 1, 1, 0, 64'hA, 4'b0010};
    tbl[4] = '{0, 0, 64'h0, 1, 1, 1, 0, 64'hB, 4'b0010};
    tbl[5] = '{0, 0, 64'h0, 1, 1, 1, 0, 64'hC, 4'b0000};
    tbl[6] = '{1, 0, 64'hD, 1, 0, 0, 1, 64'h0, 4'b0001};
    tbl[7] = '{0, 0, 64'h0, 1, 0, 1, 0, 64'hD, 4'b0000};
    tbl[8] = '{0, 0, 64'h0, 1, 3, 0, 1, 64'h0, 4'b0000};
    for (int i = 0; i < 9; i++) begin
      step(tbl[i].wv, tbl[i].wt, tbl[i].wd, tbl[i].rr, tbl[i].rt, acc, ad);
      chk($sformatf("tbl%0d_valid", i), 64'(rd_valid), 64'(tbl[i].ev));
      chk($sformatf("tbl%0d_miss", i), 64'(rd_miss), 64'(tbl[i].em));
      chk($sformatf("tbl%0d_ne", i), 64'(nonempty), 64'(tbl[i].ene));
      if (tbl[i].ev) chk($sformatf("tbl%0d_data", i), rd_data, tbl[i].ed);
    end

    // Fill color 2, overflow it, then read+write at full drops the write.
    for (int i = 0; i < DEPTH; i++) step(1, 2, 64'h2000 + 64'(i), 0, 0, acc, ad);
    chk("full_no_ovf", 64'(overflow), 64'd0);
    step(1, 2, 64'hDEAD, 0, 0, acc, ad);
    chk("ovf_set", 64'(overflow), 64'd1);
    step(1, 2, 64'hBEEF, 1, 2, acc, ad);
    chk("full_rw_data", rd_data, 64'h2000);
    for (int i = 1; i < DEPTH; i++) begin
      step(0, 0, 64'h0, 1, 2, acc, ad);
      chk("drain_data", rd_data, 64'h2000 + 64'(i));
    end
    step(0, 0, 64'h0, 1, 2, acc, ad);
    chk("drain_miss", 64'(rd_miss), 64'd1);
    chk("ovf_sticky", 64'(overflow), 64'd1);

    // Interleave with color 3 carrying more than 2*DEPTH entries to wrap its pointers.
    t3w = 0;
    for (int i = 0; i < 2 * (2 * DEPTH + 8); i++) begin
      int wt;
      int rt;
      wt = (i % 2 == 0) ? 3 : int'($urandom_range(0, 2));
      rt = (i % 2 == 1) ? 3 : int'($urandom_range(0, 2));
      if (wt == 3) t3w++;
      step(1, wt, {$urandom, $urandom}, (i > 6), rt, acc, ad);
    end
    chk("t3_wrapped", 64'(t3w >= 2 * DEPTH), 64'd1);

    // Random traffic with a mid-run reset.
    for (int i = 0; i < 2000; i++) begin
      if (i == 1000) begin
        do_reset();
        step(0, 0, 64'h0, 1, int'($urandom_range(0, 3)), acc, ad);
        chk("post_rst_miss", 64'(rd_miss), 64'd1);
      end
      step(($urandom_range(0, 99) < 55), int'($urandom_range(0, 3)), {$urandom, $urandom},
           ($urandom_range(0, 99) < 50), int'($urandom_range(0, 3)), acc, ad);
    end

`ifdef COLORED_RETURN_BUFFER_LEVEL_EN
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 0, 64'(i), 0, 0, acc, ad);
    chk("level5", 64'(level), 64'd5);
    for (int i = 0; i < 2; i++) step(0, 0, 64'h0, 1, 0, acc, ad);
    chk("level3", 64'(level), 64'd3);
    step(1, 1, 64'h77, 1, 0, acc, ad);
    chk("level3_rw", 64'(level), 64'd3);
`endif

    for (int c = 0; c < COLORS; c++) chk($sformatf("pops_tag%0d", c), 64'(d_pops[c]), 64'(m_pops[c]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
